fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequences instruction fetch for the single-issue core. Owns the fetch PC and issues one instruction-memory request at a time over a valid/ready handshake. Returns each instruction with its PC to decode under backpressure, and applies branch/jump redirects from execute, discarding stale in-flight responses. It sits between the PC-next logic (redirect source) and the decode stage.

## Interface
- RESET_PC, 32'h00000000, fetch address after reset
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  taken branch/JAL/JALR this cycle
- redirect_pc  in  32  redirect target
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  request byte address
- imem_rsp_valid  in  1  response valid, one cycle pulse; never before acceptance
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction presented to decode
- if_ready  in  1  decode accepts (low = stall)
- if_instr  out  32  instruction word
- if_pc  out  32  PC of if_instr
- misalign_fault  out  1  present only with FETCH_MISALIGN_TRAP_EN
- misalign_addr  out  32  present only with FETCH_MISALIGN_TRAP_EN

## Operation
- Reset (async, reset_n low): state IDLE, fetch_pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, misalign_fault=0, misalign_addr=0.
- At most one request outstanding. imem_req_valid=1 only in REQ. imem_req_addr=fetch_pc at all times.
- States and transitions. Redirect has priority over everything except reset.
  - IDLE: next edge -> REQ. Redirect: fetch_pc<=target.
  - REQ: on redirect, fetch_pc<=target and stay in REQ. The address may change before acceptance; this is the only legal address change while valid. Else, if req_ready, -> WAIT.
  - WAIT: if rsp_valid without redirect, if_instr<=data, if_pc<=fetch_pc, if_valid<=1, fetch_pc<=fetch_pc+4, -> HOLD. If rsp_valid with redirect, discard the response, fetch_pc<=target, -> REQ. If redirect only, fetch_pc<=target, -> DROP.
  - HOLD: if_valid held with if_instr and if_pc stable until accepted. On redirect, if_valid<=0, fetch_pc<=target, -> REQ. Else, if if_ready, if_valid<=0, -> REQ.
  - DROP: wait for rsp_valid, discard it, -> REQ. A redirect here updates fetch_pc and stays in DROP.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0 with no flag.
- Without the macro, targets are aligned: fetch_pc <= {redirect_pc[31:2],2'b00}.

## Timing
- After reset release: first edge to REQ; imem_req_valid high from that edge.
- Zero-wait memory (ready=1, rsp the cycle after acceptance): if_valid rises 2 cycles after the request cycle.
- Steady throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect to the new request takes 1 cycle, or waits for the stale response in DROP.
- All outputs are registered except imem_req_valid and imem_req_addr, which are decoded from state/fetch_pc flops.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign_fault=1 (sticky) and misalign_addr=redirect_pc.
  - The sequencer enters FAULT, going through DROP first if a response is outstanding. FAULT issues no requests and keeps if_valid=0.
  - Only an aligned redirect (-> REQ, fault cleared) or reset exits FAULT.
- Undefined: no FAULT state and no misalign ports; low two target bits are forced to zero.

## Structure
- fetch_pkg: state enum (IDLE, REQ, WAIT, HOLD, DROP, FAULT), INSTR_BYTES=4, default RESET_PC constant.
- No sub-module: the +4 adder and next-state logic stay inline in fetch_sequencer.

## Test plan
- Reset release, memory ready=1, 1-cycle response, if_ready=1 -> requests at 0x0, 0x4, 0x8 each 3 cycles apart; if_pc 0x0, 0x4, 0x8 with matching data.
- if_ready low for 5 cycles in HOLD at pc 0x8 -> if_valid, if_instr, if_pc stable; no new request; fetch resumes at 0xC after release.
- Redirect to 0x100 in WAIT, response 3 cycles later -> response dropped, never on if_valid; next request addr 0x100.
- Redirect to 0x200 in the same cycle as rsp_valid -> data discarded; REQ at 0x200 next cycle.
- req_ready held low 4 cycles with redirect to 0x40 mid-wait -> address switches to 0x40 and stays until accepted.
- Macro on: redirect to 0x102 -> misalign_fault=1, misalign_addr=0x102, no requests. Redirect to 0x104 -> fault clears, request at 0x104. Macro off: same redirect -> request at 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Fetch states, instruction size and the default reset PC.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP,
        FAULT
    } state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: one imem request in flight, decode handshake, redirects.
// Optional FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_fault,
    output logic [31:0] misalign_addr
`endif
);

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] pc_inc;
    logic [31:0] target;
    state_t      redir_to;
    state_t      drop_exit;

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = fetch_pc;
    assign pc_inc         = fetch_pc + 32'(INSTR_BYTES);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic bad_target;

    assign bad_target = |redirect_pc[1:0];
    assign target     = redirect_pc;
    assign redir_to   = bad_target ? FAULT : REQ;
    // a pending fault is entered once the stale response has drained
    assign drop_exit  = misalign_fault ? FAULT : REQ;
`else
    logic unused_lsb;

    assign unused_lsb = ^redirect_pc[1:0];
    assign target     = align_pc(redirect_pc);
    assign redir_to   = REQ;
    assign drop_exit  = REQ;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
            misalign_addr  <= 32'h0;
`endif
        end else begin
            if (redirect_valid) begin
                fetch_pc <= target;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (bad_target) begin
                    misalign_fault <= 1'b1;
                    misalign_addr  <= redirect_pc;
                end else begin
                    misalign_fault <= 1'b0;
                end
`endif
            end
            unique case (state)
                IDLE: begin
                    state <= redirect_valid ? redir_to : REQ;
                end
                REQ: begin
                    if (redirect_valid)
                        state <= redir_to;
                    else if (imem_req_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (redirect_valid) begin
                        state <= imem_rsp_valid ? redir_to : DROP;
                    end else if (imem_rsp_valid) begin
                        if_instr <= imem_rsp_data;
                        if_pc    <= fetch_pc;
                        if_valid <= 1'b1;
                        fetch_pc <= pc_inc;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        if_valid <= 1'b0;
                        state    <= redir_to;
                    end else if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= REQ;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid)
                        state <= redirect_valid ? redir_to : drop_exit;
                end
                FAULT: begin
                    if (redirect_valid)
                        state <= redir_to;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed timing cases, then
// randomized traffic against a transaction-level fetch-stream model.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_fault;
    logic [31:0] misalign_addr;
`endif

    fetch_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault),
        .misalign_addr  (misalign_addr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model of the expected fetch stream and the memory
    logic [31:0] exp_pc;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          lat;
    bit          mem_ready;
    int          cyc;
    bit          hold_prev;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    int          acc_cyc[$];
    logic [31:0] acc_addr[$];
    int          dlv_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        bit fire;
        bit acc;
        bit dlv;
        fire = pend && (pend_cnt == 0);
        imem_rsp_valid = fire;
        imem_rsp_data  = fire ? mem_word(pend_addr) : 32'h0;
        imem_req_ready = mem_ready && !redirect_valid;
        acc = imem_req_valid && imem_req_ready;
        dlv = if_valid && if_ready && !redirect_valid;
        if (hold_prev) begin
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_pc", if_pc, prev_pc);
            chk("hold_instr", if_instr, prev_instr);
        end
        chk("one_outstanding", 32'(imem_req_valid && pend), 32'd0);
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] == 2'b00)
                exp_pc = redirect_pc;
`else
            exp_pc = {redirect_pc[31:2], 2'b00};
`endif
        end
        if (acc) begin
            chk("req_addr", imem_req_addr, exp_pc);
            acc_cyc.push_back(cyc);
            acc_addr.push_back(imem_req_addr);
        end
        if (dlv) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            dlv_cyc.push_back(cyc);
        end
        hold_prev  = if_valid && !dlv && !redirect_valid;
        prev_pc    = if_pc;
        prev_instr = if_instr;
        if (fire)
            pend = 1'b0;
        else if (pend)
            pend_cnt--;
        if (acc) begin
            pend      = 1'b1;
            pend_cnt  = lat - 1;
            pend_addr = imem_req_addr;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
    endtask

    task automatic redir(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        tick();
    endtask

    task automatic run_until_acc(input int max, input string tag);
        int n0;
        n0 = acc_cyc.size();
        for (int i = 0; i < max && acc_cyc.size() == n0; i++)
            tick();
        chk({tag, "_timeout"}, 32'(acc_cyc.size() > n0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b0;
        pend = 0; pend_cnt = 0; pend_addr = 0;
        hold_prev = 0; prev_pc = 0; prev_instr = 0;
        exp_pc = 32'h0; lat = 1; mem_ready = 1; cyc = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_fault", 32'(misalign_fault), 32'd0);
        chk("rst_maddr", misalign_addr, 32'h0);
`endif
        reset_n  = 1'b1;
        if_ready = 1'b1;

        // zero-wait streaming: request every 3 cycles
        repeat (9) tick();
        chk("acc0_cyc", 32'(acc_cyc[0]), 32'd1);
        chk("acc_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        chk("acc_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        chk("acc_addr0", acc_addr[0], 32'h0);
        chk("acc_addr1", acc_addr[1], 32'h4);
        chk("acc_addr2", acc_addr[2], 32'h8);
        chk("first_valid_lat", 32'(dlv_cyc[0] - acc_cyc[0]), 32'd2);
        chk("hold8_valid", 32'(if_valid), 32'd1);
        chk("hold8_pc", if_pc, 32'h8);

        // decode stall in HOLD
        if_ready = 1'b0;
        n = acc_cyc.size();
        repeat (5) tick();
        chk("stall_no_req", 32'(acc_cyc.size()), 32'(n));
        if_ready = 1'b1;
        lat = 4;
        run_until_acc(10, "resume");
        chk("resume_addr", acc_addr[$], 32'hC);

        // redirect in WAIT, stale response 3 cycles later
        a = acc_cyc[$];
        n = dlv_cyc.size();
        redir(32'h100);
        lat = 1;
        run_until_acc(12, "drop");
        chk("drop_addr", acc_addr[$], 32'h100);
        chk("drop_lat", 32'(acc_cyc[$] - a), 32'd5);
        chk("drop_no_dlv", 32'(dlv_cyc.size()), 32'(n));

        // redirect coincident with the response
        redir(32'h200);
        chk("rsp_redir_valid", 32'(imem_req_valid), 32'd1);
        chk("rsp_redir_addr", imem_req_addr, 32'h200);

        // memory not ready, address switch before acceptance
        mem_ready = 1'b0;
        tick();
        tick();
        redir(32'h40);
        chk("sw_addr", imem_req_addr, 32'h40);
        tick();
        chk("sw_valid", 32'(imem_req_valid), 32'd1);
        chk("sw_addr_hold", imem_req_addr, 32'h40);
        mem_ready = 1'b1;
        tick();
        chk("sw_acc_addr", acc_addr[$], 32'h40);

        // misaligned redirect target
`ifdef FETCH_MISALIGN_TRAP_EN
        redir(32'h102);
        n = acc_cyc.size();
        repeat (6) tick();
        chk("fault_no_req", 32'(acc_cyc.size()), 32'(n));
        chk("fault_flag", 32'(misalign_fault), 32'd1);
        chk("fault_addr", misalign_addr, 32'h102);
        chk("fault_if_valid", 32'(if_valid), 32'd0);
        redir(32'h104);
        chk("fault_clear", 32'(misalign_fault), 32'd0);
        run_until_acc(6, "unfault");
        chk("unfault_addr", acc_addr[$], 32'h104);
`else
        redir(32'h102);
        run_until_acc(6, "align");
        chk("align_addr", acc_addr[$], 32'h100);
`endif

        // PC wraps at the top of the address space
        redir(32'hFFFF_FFFC);
        run_until_acc(6, "wrap_a");
        chk("wrap_addr_a", acc_addr[$], 32'hFFFF_FFFC);
        run_until_acc(10, "wrap_b");
        chk("wrap_addr_b", acc_addr[$], 32'h0);

        // randomized traffic against the stream model
        n = dlv_cyc.size();
        for (int i = 0; i < 1500; i++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            if_ready  = ($urandom_range(0, 2) != 0);
            lat       = int'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                redirect_pc = $urandom() & 32'hFFFF_FFFC;
`else
                redirect_pc = $urandom();
`endif
            end
            tick();
        end
        chk("liveness", 32'(dlv_cyc.size() - n > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
